// File: rtl/drain_pkg.sv
// Shared types and sizing for the M4 drain streamer.
// Beat width times BEATS_PER_WORD must equal the SRAM word width.
package drain_pkg;

  localparam int WORD_W         = 128;
  localparam int BEAT_W         = 32;
  localparam int ADDR_W         = 16;
  localparam int BEATS_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

endpackage

// File: rtl/drain_word_fifo.sv
// Two-entry word FIFO between the M4 read port and the beat serialiser.
// Caller never pushes when full or pops when empty.
module drain_word_fifo #(
  parameter int W = 128
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wp_q;
  logic         rp_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= ~wp_q;
      end
      if (pop_i) begin
        rp_q <= ~rp_q;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rp_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/m4_drain_streamer.sv
// Streams word_count M4 words out as 32-bit beats, lowest beat first.
// Define DRAIN_PARITY_EN to add the out_parity beat-parity output.
module m4_drain_streamer #(
  parameter int WORD_W = drain_pkg::WORD_W,
  parameter int BEAT_W = drain_pkg::BEAT_W,
  parameter int ADDR_W = drain_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic [ADDR_W-1:0] M4_ReadAddress,
  input  logic [WORD_W-1:0] M4_ReadBus,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef DRAIN_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  import drain_pkg::*;

  localparam int BW = $clog2(BEATS_PER_WORD);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] issued_q;
  logic [ADDR_W-1:0] popped_q;
  logic [BW-1:0]     beat_q;
  logic              inflight_q;

  logic              accept;
  logic              issue;
  logic              hs;
  logic              pop;
  logic              last_beat;
  logic              last_word;
  logic [1:0]        occ;
  logic [1:0]        pend;
  logic              full;
  logic              empty;
  logic [WORD_W-1:0] head;
  logic [BEAT_W-1:0] beats [BEATS_PER_WORD];

  drain_word_fifo #(
    .W (WORD_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (inflight_q),
    .din_i   (M4_ReadBus),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occ)
  );

  always_comb begin
    for (int k = 0; k < BEATS_PER_WORD; k++) begin
      beats[k] = head[k*BEAT_W +: BEAT_W];
    end
  end

  // Buffered plus in-flight words bound how far reads run ahead.
  assign pend      = occ + {1'b0, inflight_q};
  assign last_beat = (beat_q == BW'(BEATS_PER_WORD - 1));
  assign last_word = (popped_q == count_q - 1'b1);

  assign out_valid = (state_q == RUN) && !empty;
  assign hs        = out_valid && out_ready;
  assign pop       = hs && last_beat;
  assign out_data  = out_valid ? beats[beat_q] : '0;
  assign out_last  = out_valid && last_beat && last_word;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == FINISH);

  assign M4_ReadAddress = base_q + issued_q;

`ifdef DRAIN_PARITY_EN
  assign out_parity = ^out_data;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (word_count == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        issue = (issued_q != count_q) && (pend < 2'd2) && !full;
        if (pop && last_word) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept) begin
        base_q   <= base_addr;
        count_q  <= word_count;
        issued_q <= '0;
        popped_q <= '0;
        beat_q   <= '0;
      end else begin
        if (issue) issued_q <= issued_q + 1'b1;
        if (hs)    beat_q   <= beat_q + 1'b1;
        if (pop)   popped_q <= popped_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m4_drain_streamer.sv
// Randomized bench for m4_drain_streamer against a queue-based beat model.
// Parity checks are active when DRAIN_PARITY_EN is defined.
module tb_m4_drain_streamer;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [15:0]  word_count = '0;
  logic [15:0]  M4_ReadAddress;
  logic [127:0] M4_ReadBus = '0;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic         busy;
  logic         done;
`ifdef DRAIN_PARITY_EN
  logic         out_parity;
`endif

  m4_drain_streamer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .M4_ReadAddress (M4_ReadAddress),
    .M4_ReadBus     (M4_ReadBus),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done)
`ifdef DRAIN_PARITY_EN
    ,
    .out_parity     (out_parity)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  logic [127:0] mem [logic [15:0]];

  function automatic logic [127:0] rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 128'h0;
  endfunction

  // SRAM read port: data valid one cycle after the address.
  always @(posedge clock) M4_ReadBus <= rd(M4_ReadAddress);

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q [$];
  int          ncyc = 0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          hs_cnt = 0;
  int          valid_cnt = 0;
  logic [15:0] run_base = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  int          rmode = 0;
  int          ph = 0;

  // Ready generator: 0 = always, 1 = 1,0,0,1 pattern, 2 = random.
  always @(posedge clock) begin
    #1;
    case (rmode)
      1:       out_ready = (ph % 4 == 0) || (ph % 4 == 3);
      2:       out_ready = 1'($urandom % 2);
      default: out_ready = 1'b1;
    endcase
    ph++;
  end

  always @(negedge clock) begin
    logic [31:0] e;
    logic [15:0] off;
    ncyc++;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (start && !busy && !done) acc_cyc = ncyc;
      if (done) begin
        done_cnt++;
        done_cyc = ncyc;
        chk("busy_at_done", busy, 0);
      end
      if (busy) begin
        off = M4_ReadAddress - run_base;
        chk("addr_ahead", (int'(off) <= hs_cnt / 4 + 2), 1);
      end
      if (out_valid) begin
        valid_cnt++;
        if (prev_stall) begin
          chk("stall_data", out_data, prev_data);
          chk("stall_last", out_last, prev_last);
        end
`ifdef DRAIN_PARITY_EN
        chk("parity", out_parity, ^out_data);
        if (out_data == 32'h7) chk("parity_7", out_parity, 1);
        if (out_data == 32'h3) chk("parity_3", out_parity, 0);
`endif
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", out_data, 0);
            chk("extra_beat_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat", out_data, e);
            chk("last", out_last, exp_q.size() == 0);
          end
          hs_cnt++;
        end
        prev_stall = !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end else begin
        if (prev_stall) chk("valid_held", out_valid, 1);
        prev_stall = 1'b0;
      end
    end
  end

  task automatic load_exp(input logic [15:0] b, input int n);
    logic [127:0] w;
    for (int i = 0; i < n; i++) begin
      w = rd(b + 16'(i));
      for (int k = 0; k < 4; k++) exp_q.push_back(w[32*k +: 32]);
    end
  endtask

  task automatic run(input logic [15:0] b, input int n, input int mode,
                     input bit ign);
    int t;
    int dc0;
    int vc0;
    rmode = mode;
    load_exp(b, n);
    @(posedge clock);
    #1;
    hs_cnt = 0;
    run_base = b;
    dc0 = done_cnt;
    vc0 = valid_cnt;
    base_addr = b;
    word_count = 16'(n);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    base_addr = 16'($urandom);
    word_count = 16'($urandom);
    t = 0;
    while (!done && t < n * 20 + 40) begin
      @(posedge clock);
      #1;
      start = ign && (t == 6);
      t++;
    end
    chk("done_seen", done, 1);
    // Start in the done cycle must be ignored.
    start = 1'b1;
    word_count = 16'h0;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("done_once", done_cnt - dc0, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("beats", hs_cnt, n * 4);
    if (mode == 0) chk("latency", done_cyc - acc_cyc, (n == 0) ? 1 : 4 * n + 3);
    if (n == 0) chk("no_valid", valid_cnt - vc0, 0);
    exp_q.delete();
  endtask

  task automatic fill(input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mem[b + 16'(i)] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  initial begin
    int t;
    int dc0;
    logic [15:0] b;
    int n;
    int m;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", M4_ReadAddress, 0);
`ifdef DRAIN_PARITY_EN
    chk("rst_parity", out_parity, 0);
`endif
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;

    mem[16'h0010] = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
    mem[16'h0011] = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    run(16'h0010, 2, 0, 1'b0);
    run(16'h0010, 2, 1, 1'b0);
    run(16'h0010, 2, 0, 1'b1);

    mem[16'hFFFF] = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    mem[16'h0000] = 128'h11112222_33334444_55556666_77778888;
    mem[16'h0001] = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    run(16'hFFFF, 2, 0, 1'b0);

    run(16'h0123, 0, 0, 1'b0);

    mem[16'h0020] = {32'h0, 32'h0, 32'h3, 32'h7};
    run(16'h0020, 1, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      b = 16'($urandom);
      if (r == 3) b = 16'hFFFD;
      n = $urandom_range(1, 6);
      m = $urandom_range(0, 2);
      if (r == 5) n = 4;
      fill(b, n);
      run(b, n, m, r == 5);
    end

    // Reset during beat 5 of a 4-word drain.
    fill(16'h0300, 4);
    rmode = 0;
    load_exp(16'h0300, 4);
    @(posedge clock);
    #1;
    hs_cnt = 0;
    run_base = 16'h0300;
    base_addr = 16'h0300;
    word_count = 16'd4;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    t = 0;
    while (hs_cnt < 4 && t < 100) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("pre_rst_hs", hs_cnt, 4);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    dc0 = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", M4_ReadAddress, 0);
`ifdef DRAIN_PARITY_EN
    chk("mid_rst_parity", out_parity, 0);
`endif
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    exp_q.delete();
    repeat (6) @(posedge clock);
    #1;
    chk("no_done_after_rst", done_cnt - dc0, 0);
    chk("idle_after_rst", out_valid, 0);

    fill(16'h0500, 3);
    run(16'h0500, 3, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
